// File: rtl/key_direction_encoder.sv
// Navigation key encoder: synchronizes and debounces four active-low buttons,
// rejects chords, and emits a registered direction code with a one-cycle strobe.

module KeyDebounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic keyN_i,
  output logic debounced_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  logic             deb_q;
  logic             deb_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A run of DEBOUNCE_CYCLES differing samples flips the debounced level.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= keyN_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign debounced_o = deb_q;

endmodule

module key_direction_encoder #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       Enable,
  input  logic [3:0] KEY_N,
  output logic [1:0] Dir_out,
  output logic       DirValid,
  output logic       KeyHeld
);

  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_RATE_LAST  = REP_W'(REPEAT_RATE - 1);
  localparam logic [REP_W-1:0] REP_ONE        = REP_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT,
    WAIT_RELEASE
  } state_t;

  state_t           state_q;
  logic [REP_W-1:0] repCnt_q;
  logic [3:0]       heldVec_q;
  logic [1:0]       dirOut_q;
  logic             dirValid_q;
  logic             keyHeld_q;

  logic [3:0]       debN;
  logic [3:0]       pressed;
  logic             anyPressed;
  logic             onePressed;
  logic [1:0]       pressCode;
  logic [REP_W-1:0] repLimit;
  logic             repeatDue;

  for (genvar g = 0; g < 4; g++) begin : gKey
    KeyDebounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uDebounce (
      .CLOCK      (CLOCK),
      .RESET_N    (RESET_N),
      .keyN_i     (KEY_N[g]),
      .debounced_o(debN[g])
    );
  end

  assign pressed    = ~debN;
  assign anyPressed = |pressed;

  always_comb begin
    onePressed = 1'b1;
    pressCode  = 2'b00;
    case (pressed)
      4'b1000: pressCode = 2'b00;
      4'b0100: pressCode = 2'b01;
      4'b0010: pressCode = 2'b10;
      4'b0001: pressCode = 2'b11;
      default: onePressed = 1'b0;
    endcase
  end

  // The guard on dirValid_q keeps strobes apart even for tiny repeat periods.
  assign repLimit  = (state_q == HOLD) ? REP_DELAY_LAST : REP_RATE_LAST;
  assign repeatDue = (repCnt_q >= repLimit) && !dirValid_q;

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      repCnt_q   <= '0;
      heldVec_q  <= 4'b1111;
      dirOut_q   <= 2'b00;
      dirValid_q <= 1'b0;
      keyHeld_q  <= 1'b0;
    end else begin
      dirValid_q <= 1'b0;
      if (!Enable) begin
        repCnt_q  <= '0;
        keyHeld_q <= 1'b0;
        state_q   <= anyPressed ? WAIT_RELEASE : IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (onePressed) begin
              dirValid_q <= 1'b1;
              dirOut_q   <= pressCode;
              heldVec_q  <= debN;
              repCnt_q   <= '0;
              keyHeld_q  <= 1'b1;
              state_q    <= HOLD;
            end else if (anyPressed) begin
              state_q <= WAIT_RELEASE;
            end
          end
          HOLD, REPEAT: begin
            // Any change of the held pattern other than a full release is a chord.
            if (!anyPressed) begin
              repCnt_q  <= '0;
              keyHeld_q <= 1'b0;
              state_q   <= IDLE;
            end else if (debN != heldVec_q) begin
              repCnt_q  <= '0;
              keyHeld_q <= 1'b0;
              state_q   <= WAIT_RELEASE;
            end else if (repeatDue) begin
              dirValid_q <= 1'b1;
              repCnt_q   <= '0;
              state_q    <= REPEAT;
            end else begin
              repCnt_q <= repCnt_q + REP_ONE;
            end
          end
          WAIT_RELEASE: begin
            if (!anyPressed) begin
              state_q <= IDLE;
            end
          end
          default: begin
            keyHeld_q <= 1'b0;
            state_q   <= IDLE;
          end
        endcase
      end
    end
  end

  assign Dir_out  = dirOut_q;
  assign DirValid = dirValid_q;
  assign KeyHeld  = keyHeld_q;

endmodule

// File: tb/tb_key_direction_encoder.sv
// Bench for key_direction_encoder: vector table, directed corner sequences and
// random key traffic compared every cycle against a windowed behavioural model.

module tb_key_direction_encoder;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic       CLOCK = 1'b0;
  logic       RESET_N;
  logic       Enable;
  logic [3:0] KEY_N;
  logic [1:0] Dir_out;
  logic       DirValid;
  logic       KeyHeld;

  int assertions = 0;
  int failures   = 0;
  int cyc        = 0;
  int pulseEdges[$];

  // Reference state: debounced vector, raw sample history, hold bookkeeping.
  logic [3:0] mDeb;
  logic [3:0] hist[$];
  int         mMode;
  logic [3:0] mHeld;
  int         mLast;
  int         mStrobes;
  logic [1:0] eDir;
  logic       eValid;
  logic       eHeld;

  typedef struct {
    logic [3:0] keyN;
    bit         en;
    int         hold;
    int         expPulses;
    logic [1:0] expDir;
  } vec_t;

  vec_t vecs[7];

  key_direction_encoder #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .Enable  (Enable),
    .KEY_N   (KEY_N),
    .Dir_out (Dir_out),
    .DirValid(DirValid),
    .KeyHeld (KeyHeld)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] k, input bit en, input int cycles);
    KEY_N  = k;
    Enable = en;
    repeat (cycles) @(negedge CLOCK);
  endtask

  // A key's debounced level flips once its last D synchronized samples all
  // disagree with it; the synchronized sample seen at edge n is raw edge n-2.
  task automatic modelStep(input int edgeIdx);
    logic [3:0] pr;
    logic [3:0] newDeb;
    int         n;
    bit         allDiffer;
    if (RESET_N !== 1'b1) begin
      mDeb = 4'b1111;
      hist.delete();
      for (int i = 0; i < D + 1; i++) hist.push_back(4'b1111);
      mMode    = 0;
      mStrobes = 0;
      eDir     = 2'b00;
      eValid   = 1'b0;
      eHeld    = 1'b0;
    end else begin
      pr     = ~mDeb;
      n      = $countones(pr);
      eValid = 1'b0;
      if (!Enable) begin
        mMode = (n != 0) ? 2 : 0;
      end else if (mMode == 0) begin
        if (n == 1) begin
          for (int k = 0; k < 4; k++) if (pr[k]) eDir = 2'(3 - k);
          eValid   = 1'b1;
          mHeld    = mDeb;
          mLast    = edgeIdx;
          mStrobes = 1;
          mMode    = 1;
        end else if (n > 1) begin
          mMode = 2;
        end
      end else if (mMode == 1) begin
        if (n == 0) mMode = 0;
        else if (mDeb != mHeld) mMode = 2;
        else if (edgeIdx - mLast == ((mStrobes == 1) ? RD : RR)) begin
          eValid = 1'b1;
          mLast  = edgeIdx;
          mStrobes++;
        end
      end else if (n == 0) begin
        mMode = 0;
      end
      eHeld = (mMode == 1);
      newDeb = mDeb;
      for (int k = 0; k < 4; k++) begin
        allDiffer = 1'b1;
        for (int j = 1; j <= D; j++)
          if (hist[hist.size() - 1 - j][k] == mDeb[k]) allDiffer = 1'b0;
        if (allDiffer) newDeb[k] = ~mDeb[k];
      end
      mDeb = newDeb;
      hist.push_back(KEY_N);
      if (hist.size() > D + 2) void'(hist.pop_front());
    end
  endtask

  initial forever begin
    int edgeIdx;
    @(posedge CLOCK);
    edgeIdx = cyc;
    cyc++;
    modelStep(edgeIdx);
    #1;
    checkOutput("DirValid", 32'(DirValid), 32'(eValid));
    checkOutput("Dir_out", 32'(Dir_out), 32'(eDir));
    checkOutput("KeyHeld", 32'(KeyHeld), 32'(eHeld));
    if (DirValid === 1'b1) pulseEdges.push_back(edgeIdx);
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    int p;
    int r;
    logic [3:0] one;
    logic [3:0] k;

    vecs[0] = '{4'b1011, 1'b1, 10, 1, 2'b01};
    vecs[1] = '{4'b0111, 1'b1, 10, 1, 2'b00};
    vecs[2] = '{4'b1101, 1'b1, 10, 1, 2'b10};
    vecs[3] = '{4'b1110, 1'b1, 10, 1, 2'b11};
    vecs[4] = '{4'b0101, 1'b1, 10, 0, 2'b11};
    vecs[5] = '{4'b1011, 1'b1, 25, 2, 2'b01};
    vecs[6] = '{4'b1110, 1'b0, 10, 0, 2'b01};

    RESET_N = 1'b0;
    Enable  = 1'b1;
    KEY_N   = 4'b1111;
    repeat (3) @(negedge CLOCK);
    checkOutput("reset Dir_out", 32'(Dir_out), 32'd0);
    checkOutput("reset DirValid", 32'(DirValid), 32'd0);
    checkOutput("reset KeyHeld", 32'(KeyHeld), 32'd0);
    RESET_N = 1'b1;
    applyStimulus(4'b1111, 1'b1, 4);

    for (int i = 0; i < 7; i++) begin
      pulseEdges.delete();
      applyStimulus(vecs[i].keyN, vecs[i].en, vecs[i].hold);
      applyStimulus(4'b1111, 1'b1, 14);
      checkOutput($sformatf("vec%0d pulses", i), 32'(pulseEdges.size()), 32'(vecs[i].expPulses));
      checkOutput($sformatf("vec%0d Dir_out", i), 32'(Dir_out), 32'(vecs[i].expDir));
      checkOutput($sformatf("vec%0d KeyHeld", i), 32'(KeyHeld), 32'd0);
    end

    $display("[TB] bounce on left key");
    pulseEdges.delete();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0111, 1'b1, 2);
      applyStimulus(4'b1111, 1'b1, 2);
    end
    s = cyc;
    applyStimulus(4'b0111, 1'b1, 12);
    applyStimulus(4'b1111, 1'b1, 14);
    checkOutput("bounce pulses", 32'(pulseEdges.size()), 32'd1);
    if (pulseEdges.size() > 0) checkOutput("bounce pulse edge", 32'(pulseEdges[0]), 32'(s + D + 2));
    checkOutput("bounce Dir_out", 32'(Dir_out), 32'd0);

    $display("[TB] auto-repeat on right key");
    pulseEdges.delete();
    s = cyc;
    applyStimulus(4'b1110, 1'b1, 60);
    applyStimulus(4'b1111, 1'b1, 14);
    checkOutput("repeat pulses", 32'(pulseEdges.size()), 32'd6);
    for (int i = 0; i < 6 && i < pulseEdges.size(); i++)
      checkOutput($sformatf("repeat edge%0d", i), 32'(pulseEdges[i]),
                  32'(s + D + 2 + ((i == 0) ? 0 : RD + RR * (i - 1))));
    checkOutput("repeat Dir_out", 32'(Dir_out), 32'd3);

    $display("[TB] chord added during hold");
    pulseEdges.delete();
    applyStimulus(4'b1101, 1'b1, 10);
    applyStimulus(4'b0101, 1'b1, 30);
    applyStimulus(4'b1111, 1'b1, 14);
    checkOutput("chord pulses", 32'(pulseEdges.size()), 32'd1);
    applyStimulus(4'b1101, 1'b1, 10);
    applyStimulus(4'b1111, 1'b1, 14);
    checkOutput("chord repress pulses", 32'(pulseEdges.size()), 32'd2);
    checkOutput("chord Dir_out", 32'(Dir_out), 32'd2);

    $display("[TB] enable gating");
    pulseEdges.delete();
    s = cyc;
    applyStimulus(4'b1011, 1'b1, 36);
    applyStimulus(4'b1011, 1'b0, 20);
    applyStimulus(4'b1011, 1'b1, 30);
    applyStimulus(4'b1111, 1'b1, 14);
    p = cyc;
    applyStimulus(4'b1011, 1'b1, 10);
    applyStimulus(4'b1111, 1'b1, 14);
    checkOutput("enable pulses", 32'(pulseEdges.size()), 32'd4);
    if (pulseEdges.size() == 4) begin
      checkOutput("enable last held pulse", 32'(pulseEdges[2]), 32'(s + D + 2 + RD + RR));
      checkOutput("enable repress pulse", 32'(pulseEdges[3]), 32'(p + D + 2));
    end

    $display("[TB] reset during repeat");
    applyStimulus(4'b1110, 1'b1, 30);
    RESET_N = 1'b0;
    r = cyc;
    @(negedge CLOCK);
    RESET_N = 1'b1;
    checkOutput("midreset Dir_out", 32'(Dir_out), 32'd0);
    checkOutput("midreset DirValid", 32'(DirValid), 32'd0);
    checkOutput("midreset KeyHeld", 32'(KeyHeld), 32'd0);
    pulseEdges.delete();
    applyStimulus(4'b1110, 1'b1, 15);
    applyStimulus(4'b1111, 1'b1, 14);
    checkOutput("midreset pulses", 32'(pulseEdges.size()), 32'd1);
    if (pulseEdges.size() > 0) checkOutput("midreset pulse edge", 32'(pulseEdges[0]), 32'(r + D + 3));
    checkOutput("midreset Dir_out after", 32'(Dir_out), 32'd3);

    $display("[TB] random traffic");
    one = 4'b0001;
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6) k = ~(one << $urandom_range(0, 3));
      else if (r < 8) k = 4'($urandom);
      else k = 4'b1111;
      if ($urandom_range(0, 39) == 0) begin
        RESET_N = 1'b0;
        @(negedge CLOCK);
        RESET_N = 1'b1;
      end
      applyStimulus(k, ($urandom_range(0, 7) != 0), $urandom_range(1, 45));
    end
    applyStimulus(4'b1111, 1'b1, 14);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
